// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit word RAM that acts as the CPU bus responder.
// Requests use a waitrequest handshake with a fixed number of stall cycles.
// Writes have byte-lane enables. Illegal accesses raise a sticky fault flag.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no access in flight; a new request starts the stall sequence
// S_WAIT | stalling the requester; r_cnt counts the remaining WAIT cycles
// S_ACK  | waitrequest low; readdata valid; a legal write commits on exit
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // With a single stall cycle the WAIT state is skipped, so the reload value is unused.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic [31:0]             r_readdata;
    logic                    r_fault;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_req;
    logic                    w_illegal;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_enter_ack;
    logic                    w_drop;
    logic                    w_commit;
    logic                    w_unused;

    assign w_req     = read | write;
    assign w_illegal = (read & write) | (address[1:0] != 2'b00);
    assign w_idx     = address[ADDR_WIDTH+1:2];

    // Upper address bits are ignored, so addresses alias modulo the depth.
    assign w_unused  = ^address[31:ADDR_WIDTH+2];

    assign waitrequest = w_req & (r_state != S_ACK);
    assign readdata    = r_readdata;
    assign fault       = r_fault;

    // Next-state, stall counter and access event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_enter_ack = 1'b0;
        w_drop      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 1) begin
                        w_state_nxt = S_ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    // Requester abandoned the access: a protocol violation.
                    w_state_nxt = S_IDLE;
                    w_drop      = 1'b1;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                    w_enter_ack = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_commit    = write & ~w_illegal;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Read data captured on entry to ACK; fault is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'd0;
            r_fault    <= 1'b0;
        end else begin
            if (w_drop) begin
                r_fault <= 1'b1;
            end
            if (w_enter_ack) begin
                if (w_illegal) begin
                    r_readdata <= 32'd0;
                    r_fault    <= 1'b1;
                end else if (read) begin
                    r_readdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Byte-lane write commit on the edge leaving ACK; memory is not reset.
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    r_mem[w_idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (one and three stall cycles) share the
// address/data inputs and the reset, each with its own read/write strobes.
// A transaction-level model tracks memory, read data and the fault flag.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        rd_i [2];
    logic        wr_i [2];
    logic        wq   [2];
    logic [31:0] rdo  [2];
    logic        flt  [2];

    int          checks;
    int          errors;

    logic [31:0] mdl_mem [2][64];
    logic [31:0] mdl_rd  [2];
    logic        mdl_flt [2];
    int          wc      [2];

    mem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .address(address), .read(rd_i[0]), .write(wr_i[0]),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(wq[0]), .readdata(rdo[0]), .fault(flt[0])
    );

    mem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .address(address), .read(rd_i[1]), .write(wr_i[1]),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(wq[1]), .readdata(rdo[1]), .fault(flt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full handshake on instance s; entered and left 1 time unit after a rising edge.
    task automatic do_access(input int s, input logic [31:0] addr, input logic r, input logic w,
                             input logic [3:0] be_v, input logic [31:0] d);
        int          hi;
        logic        done;
        logic        illegal;
        logic [5:0]  idx;
        logic [31:0] word;
        address    = addr;
        byteenable = be_v;
        writedata  = d;
        rd_i[s]    = r;
        wr_i[s]    = w;
        hi   = 0;
        done = 1'b0;
        for (int k = 0; k < 32 && !done; k++) begin
            @(negedge clk);
            if (wq[s] === 1'b1) begin
                hi++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        chk(s == 0 ? "wait_cycles_w1" : "wait_cycles_w3", 32'(hi), 32'(wc[s]));
        illegal = (r && w) || (addr[1:0] != 2'b00);
        idx     = addr[7:2];
        if (illegal) begin
            mdl_rd[s]  = 32'd0;
            mdl_flt[s] = 1'b1;
        end else if (r) begin
            mdl_rd[s] = mdl_mem[s][idx];
        end
        chk("readdata", rdo[s], mdl_rd[s]);
        chk("fault", 32'(flt[s]), 32'(mdl_flt[s]));
        if (!illegal && w) begin
            word = mdl_mem[s][idx];
            for (int b = 0; b < 4; b++) begin
                if (be_v[b]) word[8*b +: 8] = d[8*b +: 8];
            end
            mdl_mem[s][idx] = word;
        end
        @(posedge clk);
        #1;
        rd_i[s] = 1'b0;
        wr_i[s] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mdl_rd[s]  = 32'd0;
            mdl_flt[s] = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] addr;
        logic [31:0] d;
        int          s;
        int          kind;
        checks     = 0;
        errors     = 0;
        wc[0]      = 1;
        wc[1]      = 3;
        reset      = 1'b1;
        address    = 32'd0;
        byteenable = 4'd0;
        writedata  = 32'd0;
        for (int i = 0; i < 2; i++) begin
            rd_i[i]    = 1'b0;
            wr_i[i]    = 1'b0;
            mdl_rd[i]  = 32'd0;
            mdl_flt[i] = 1'b0;
        end

        // Reset values; waitrequest follows the request even while in reset.
        repeat (3) @(posedge clk);
        #1;
        rd_i[0] = 1'b1;
        @(negedge clk);
        chk("rst_waitreq_w1", 32'(wq[0]), 32'd1);
        chk("rst_waitreq_w3", 32'(wq[1]), 32'd0);
        chk("rst_readdata_w1", rdo[0], 32'd0);
        chk("rst_readdata_w3", rdo[1], 32'd0);
        chk("rst_fault_w1", 32'(flt[0]), 32'd0);
        chk("rst_fault_w3", 32'(flt[1]), 32'd0);
        rd_i[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Give every word a known value in both instances.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 64; j++) begin
                do_access(i, 32'(j * 4), 1'b0, 1'b1, 4'hF, 32'd0);
            end
        end

        // Basic read, full write, lane-merged write.
        do_access(0, 32'h0, 1'b1, 1'b0, 4'h0, 32'd0);
        do_access(0, 32'h10, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF);
        do_access(0, 32'h10, 1'b1, 1'b0, 4'h0, 32'd0);
        chk("full_write", rdo[0], 32'hDEADBEEF);
        do_access(0, 32'h10, 1'b0, 1'b1, 4'b0101, 32'h11223344);
        do_access(0, 32'h10, 1'b1, 1'b0, 4'h0, 32'd0);
        chk("lane_merge", rdo[0], 32'hDE22BE44);
        do_access(0, 32'h10, 1'b0, 1'b1, 4'b0000, 32'hFFFFFFFF);
        do_access(0, 32'h10, 1'b1, 1'b0, 4'h0, 32'd0);
        chk("be_zero_noop", rdo[0], 32'hDE22BE44);

        // Three stall cycles; reset mid-WAIT discards the write.
        do_access(1, 32'h10, 1'b1, 1'b0, 4'h0, 32'd0);
        do_access(1, 32'h20, 1'b0, 1'b1, 4'hF, 32'h01020304);
        address    = 32'h20;
        writedata  = 32'hCAFEF00D;
        byteenable = 4'hF;
        wr_i[1]    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        wr_i[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mdl_rd[i]  = 32'd0;
            mdl_flt[i] = 1'b0;
        end
        @(negedge clk);
        chk("reset_mid_wait_rd", rdo[1], 32'd0);
        @(posedge clk);
        #1;
        do_access(1, 32'h20, 1'b1, 1'b0, 4'h0, 32'd0);
        chk("reset_no_commit", rdo[1], 32'h01020304);

        // Misaligned read faults and the fault stays set.
        do_access(0, 32'h12, 1'b1, 1'b0, 4'h0, 32'd0);
        do_access(0, 32'h10, 1'b1, 1'b0, 4'h0, 32'd0);
        chk("fault_sticky", 32'(flt[0]), 32'd1);

        // Aliasing of high address bits.
        do_access(0, 32'hBFC00000, 1'b0, 1'b1, 4'hF, 32'hA5A5A5A5);
        do_access(0, 32'h0, 1'b1, 1'b0, 4'h0, 32'd0);
        chk("alias", rdo[0], 32'hA5A5A5A5);

        // Simultaneous read and write is illegal and leaves memory unchanged.
        do_access(1, 32'h30, 1'b0, 1'b1, 4'hF, 32'h55AA0FF0);
        do_access(1, 32'h30, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF);
        do_access(1, 32'h30, 1'b1, 1'b0, 4'h0, 32'd0);
        chk("rw_no_commit", rdo[1], 32'h55AA0FF0);

        // Request dropped mid-WAIT: back to idle with fault set and no write.
        do_reset();
        address    = 32'h30;
        writedata  = 32'h0BAD0BAD;
        byteenable = 4'hF;
        wr_i[1]    = 1'b1;
        @(posedge clk);
        #1;
        wr_i[1] = 1'b0;
        @(negedge clk);
        chk("drop_fault_before", 32'(flt[1]), 32'd0);
        @(posedge clk);
        #1;
        mdl_flt[1] = 1'b1;
        @(negedge clk);
        chk("drop_fault_after", 32'(flt[1]), 32'd1);
        chk("drop_waitreq", 32'(wq[1]), 32'd0);
        @(posedge clk);
        #1;
        do_access(1, 32'h30, 1'b1, 1'b0, 4'h0, 32'd0);
        chk("drop_no_commit", rdo[1], 32'h55AA0FF0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            s    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            ra   = $urandom();
            d    = $urandom();
            addr = {ra[31:8], 2'b00, ra[3:0], 2'b00};
            if (kind <= 4) begin
                do_access(s, addr, 1'b1, 1'b0, 4'h0, d);
            end else if (kind <= 8) begin
                do_access(s, addr, 1'b0, 1'b1, ra[7:4], d);
            end else if (ra[4]) begin
                do_access(s, addr, 1'b1, 1'b1, ra[7:4], d);
            end else begin
                addr[1:0] = (ra[5:4] == 2'b00) ? 2'b01 : ra[5:4];
                do_access(s, addr, ra[6], ~ra[6], ra[7:4], d);
            end
            if (n % 50 == 49) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port word RAM that acts as the bus responder for the multicycle CPU datapath. It answers the CPU's byte-addressed read and write requests over a waitrequest-style handshake with a programmable number of stall cycles. Byte-lane writes are supported. Illegal accesses are flagged on a sticky fault output. It sits between the CPU's memory address/write-data outputs and its read-data input, and serves as the instruction and data memory for simulation and FPGA builds.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-index bits; depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_CYCLES, 1: cycles waitrequest stays high per access; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  32  byte address; word index = address[ADDR_WIDTH+1:2].
- read  in  1  read request.
- write  in  1  write request.
- byteenable  in  4  write lane enables; bit i covers writedata[8i+7:8i].
- writedata  in  32  write data.
- waitrequest  out  1  high = request not yet accepted; requester holds all inputs stable.
- readdata  out  32  read data; valid while waitrequest is low during a read.
- fault  out  1  sticky illegal-access flag.

## Operation
- States: IDLE, WAIT, ACK. A 4-bit down-counter `cnt` is used in WAIT.
- Request = read | write. Illegal request = (read & write) or address[1:0] != 0.
- waitrequest = request & (state != ACK). This is combinational from state, read, and write.
- IDLE:
  - No request: stay in IDLE.
  - Request, WAIT_CYCLES == 1: go to ACK.
  - Request, WAIT_CYCLES > 1: go to WAIT with cnt = WAIT_CYCLES-2.
- WAIT:
  - Request still present, cnt != 0: cnt decrements.
  - Request still present, cnt == 0: go to ACK.
  - Request dropped: protocol violation. Go to IDLE, set fault, perform no write.
- Entering ACK:
  - Legal read: readdata <= mem[word index].
  - Illegal request: readdata <= 0 and fault <= 1.
  - Legal write: readdata unchanged.
- ACK (waitrequest low):
  - On the edge leaving ACK, a legal write commits: only lanes with byteenable=1 are updated.
  - byteenable = 4'b0000 is a legal no-op write.
  - Illegal accesses never modify memory.
  - Next state is always IDLE.
- Reads ignore byteenable and always return the full word.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo the depth. For example, 0xBFC00000 maps to word 0.
- readdata holds its last value outside ACK.
- fault clears only on reset.

## Timing
- Reset values: state = IDLE, cnt = 0, readdata = 0, fault = 0, waitrequest = request.
- Reset does not clear memory contents.
- Reset asserted mid-access (WAIT or ACK): the next state is IDLE and no write commits.
- A request asserted in cycle N sees waitrequest high in cycles N..N+WAIT_CYCLES-1 and low in cycle N+WAIT_CYCLES. The access completes on the edge that ends cycle N+WAIT_CYCLES.
- Back-to-back accesses: after ACK the block returns to IDLE for one cycle. A request held high through that cycle restarts the count. Throughput is one access per WAIT_CYCLES+1 cycles.
- Read-after-write to the same word: the read's ACK returns the newly written lanes merged with the old lanes.
- The requester must not change address, byteenable, writedata, read, or write while waitrequest is high. Only a dropped request is detected; other changes are undefined.

## Test plan
- Reset with WAIT_CYCLES=1 -> readdata=0, fault=0. Then read 0x0 -> waitrequest high for 1 cycle, low for 1 cycle.
- Write 0xDEADBEEF to 0x10 with be=1111, then read 0x10 -> readdata=0xDEADBEEF, fault=0.
- Write 0x11223344 to 0x10 with be=0101, then read 0x10 -> 0xDE22BE44.
- With WAIT_CYCLES=3, read 0x10 -> waitrequest high for exactly 3 cycles. Separately, write 0xCAFEF00D to 0x20, assert reset during WAIT, then read 0x20 -> old contents returned.
- Read 0x12 (misaligned) -> acknowledged on schedule, readdata=0, fault=1 and stays 1 until reset.
- Write 0xA5A5A5A5 to 0xBFC00000, then read 0x0 -> 0xA5A5A5A5 (aliasing).
- Assert read and write together on 0x30 -> fault=1 and memory at 0x30 unchanged.
- Drop the request mid-WAIT (WAIT_CYCLES=3) -> state returns to IDLE and fault=1.
